noise_stat_estimator: RTL and testbench
=======================================

Name: noise_stat_estimator

Overview:
- Measurement sink for the Gaussian noise source: consumes a stream of signed 2^7-quantised samples and estimates the sample mean and variance over a window of 2^LOG2_N samples.
- Used on-chip to confirm that the generated noise has the configured STD, and as a noise-power estimator at the receiver end of the channel model.
- Results are reported by a one-cycle valid strobe.

Parameters:
- LOG2_N, 10, log2 of the window length N; legal range 1..16.
- CONTINUOUS, 0, when 1 a new window starts automatically after each result, without a start_i pulse.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  one-cycle request to begin a window; honoured only in IDLE
- sample_i  input  16  signed sample, 2^7 quantisation (Q8.7)
- sample_valid_i  input  1  sample_i is valid this cycle
- busy_o  output  1  high in ACCUM, CALC and DONE
- mean_o  output  16  signed mean, 2^7 quantisation
- var_o  output  32  unsigned variance, 2^14 quantisation
- stat_valid_o  output  1  one-cycle strobe; mean_o and var_o are new
- peak_o  output  16  unsigned max |sample| in the window (see Optional Feature)

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - Accumulators and the sample counter clear.
  - mean_o, var_o, peak_o and stat_valid_o go to 0; busy_o goes to 0.
- States: IDLE -> ACCUM -> CALC -> DONE -> (IDLE, or ACCUM if CONTINUOUS=1).
- IDLE:
  - On start_i, clear sum, sumsq, count and peak, then go to ACCUM.
  - sample_valid_i is ignored.
- ACCUM:
  - Each cycle with sample_valid_i=1, accept the sample:
    - sum += sample_i (signed, 16+LOG2_N bits).
    - sumsq += sample_i*sample_i (unsigned, 31+LOG2_N bits; exact, no saturation).
    - count increments.
  - When the accepted sample is the N-th (count == N-1 before increment), go to CALC.
  - Cycles with sample_valid_i=0 have no effect; gaps are unlimited.
  - start_i is ignored.
- CALC (1 cycle):
  - mean = sum >>> LOG2_N (arithmetic shift, floor).
  - msq = sumsq >> LOG2_N.
  - All values are registered internally.
- DONE (1 cycle):
  - var = msq - mean*mean (2^14 units).
  - If the result is negative because of truncation, clamp to 0; if it exceeds 2^32-1, saturate.
  - Register var_o and mean_o, and pulse stat_valid_o high for exactly this cycle's output.
  - Samples arriving in CALC and DONE are dropped, not buffered.
- Latency: the last sample is accepted in cycle t; stat_valid_o=1 in cycle t+2.
- mean_o, var_o and peak_o hold their values until the next DONE.
- CONTINUOUS=1:
  - DONE clears the accumulators and enters ACCUM directly.
  - The first sample of the next window is accepted in the cycle after DONE.
- Reset mid-window: all partial results are discarded; no stat_valid_o until a new window completes.
- start_i together with rst: reset wins.

Optional Feature:
- Macro: NOISE_STAT_PEAK_EN.
- Defined: peak_o is registered at DONE with the maximum |sample_i| accepted in the window.
  - |-32768| saturates to 32767.
  - The tracker clears at window start.
- Undefined: no peak logic is built; peak_o is constant 0.

Test Plan:
- LOG2_N=4, start, 16 samples of 128 back-to-back -> stat_valid_o at last-sample cycle +2; mean_o=128, var_o=0, busy_o low the cycle after.
- LOG2_N=4, alternating +128/-128 x16 with sample_valid_i toggling every cycle -> mean_o=0, var_o=16384, exactly one stat_valid_o pulse.
- LOG2_N=4, samples 0..15 -> mean_o=7, var_o=77-49=28.
  - With NOISE_STAT_PEAK_EN: peak_o=15.
  - Without it: peak_o=0.
- LOG2_N=4, 16 samples of -32768 -> mean_o=-32768, var_o=0 (sumsq=2^34 with no overflow).
  - With NOISE_STAT_PEAK_EN: peak_o=32767.
- Rst asserted after 8 of 16 samples, then start with 16 samples of 64 -> no strobe for the aborted window; new result mean_o=64, var_o=0.
- CONTINUOUS=1, LOG2_N=2, no further start, continuous 256s -> stat_valid_o every 6 cycles (4 ACCUM + CALC + DONE), mean_o=256, var_o=0; start_i pulses during ACCUM have no effect.

Source files
------------

// File: rtl/noise_stat_estimator_if.sv
// Stream/result bundle for noise_stat_estimator.
// master: drives start/samples; slave: the estimator.
interface noise_stat_estimator_if;
   logic               start_i;
   logic signed [15:0] sample_i;
   logic               sample_valid_i;
   logic               busy_o;
   logic signed [15:0] mean_o;
   logic        [31:0] var_o;
   logic               stat_valid_o;
   logic        [15:0] peak_o;

   modport master (
      output start_i,
      output sample_i,
      output sample_valid_i,
      input  busy_o,
      input  mean_o,
      input  var_o,
      input  stat_valid_o,
      input  peak_o
   );

   modport slave (
      input  start_i,
      input  sample_i,
      input  sample_valid_i,
      output busy_o,
      output mean_o,
      output var_o,
      output stat_valid_o,
      output peak_o
   );
endinterface

// File: rtl/noise_stat_estimator.sv
// Windowed mean/variance estimator for Q8.7 noise samples.
// Ports: clk, rst (async high), bus (slave): start_i,
// sample_i, sample_valid_i in; busy_o, mean_o (Q8.7),
// var_o (2^-14 units), stat_valid_o, peak_o out.
// NOISE_STAT_PEAK_EN: build the max-|sample| tracker.
module noise_stat_estimator #(
   parameter int LOG2_N     = 10,
   parameter bit CONTINUOUS = 1'b0
) (
   input logic                   clk,
   input logic                   rst,
   noise_stat_estimator_if.slave bus
);
   localparam int SW = 16 + LOG2_N;
   localparam int QW = 31 + LOG2_N;
   localparam logic [LOG2_N-1:0] LAST = '1;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      CALC,
      DONE
   } state_t;

   state_t                   state;
   logic signed [SW-1:0]     sum;
   logic        [QW-1:0]     sumsq;
   logic        [LOG2_N-1:0] count;

   logic                     take_c;
   logic                     clear_c;
   logic signed [31:0]       prod_c;
   logic        [QW-1:0]     sq_c;
   logic signed [15:0]       mean_c;
   logic        [30:0]       msq_c;
   logic signed [31:0]       mean2_c;
   logic        [33:0]       diff_c;
   logic        [31:0]       var_c;

   assign take_c  = (state == ACCUM) && bus.sample_valid_i;
   assign clear_c = ((state == IDLE) && bus.start_i) ||
                    ((state == DONE) && CONTINUOUS);

   assign prod_c = 32'(bus.sample_i) * 32'(bus.sample_i);
   assign sq_c   = QW'($unsigned(prod_c));

   // Top slices are floor(sum/N) and floor(sumsq/N).
   assign mean_c  = sum[LOG2_N +: 16];
   assign msq_c   = sumsq[LOG2_N +: 31];
   assign mean2_c = 32'(mean_c) * 32'(mean_c);
   assign diff_c  = 34'(msq_c) - 34'(mean2_c);

   // Negative only through truncation; clamp to zero.
   always_comb begin
      var_c = diff_c[31:0];
      if (diff_c[33])
         var_c = '0;
      else if (diff_c[32])
         var_c = '1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         sum              <= '0;
         sumsq            <= '0;
         count            <= '0;
         bus.busy_o       <= 1'b0;
         bus.mean_o       <= '0;
         bus.var_o        <= '0;
         bus.stat_valid_o <= 1'b0;
      end else begin
         bus.stat_valid_o <= 1'b0;
         if (clear_c) begin
            sum   <= '0;
            sumsq <= '0;
            count <= '0;
         end
         unique case (state)
            IDLE: begin
               if (bus.start_i) begin
                  state      <= ACCUM;
                  bus.busy_o <= 1'b1;
               end
            end
            ACCUM: begin
               if (take_c) begin
                  sum   <= sum + SW'(bus.sample_i);
                  sumsq <= sumsq + sq_c;
                  count <= count + 1'b1;
                  if (count == LAST)
                     state <= CALC;
               end
            end
            CALC: begin
               // Results land so the strobe is seen in DONE.
               bus.mean_o       <= mean_c;
               bus.var_o        <= var_c;
               bus.stat_valid_o <= 1'b1;
               state            <= DONE;
            end
            DONE: begin
               if (CONTINUOUS) begin
                  state <= ACCUM;
               end else begin
                  state      <= IDLE;
                  bus.busy_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef NOISE_STAT_PEAK_EN
   logic [15:0] mag_c;
   logic [15:0] peak_trk;

   // |-32768| does not fit; saturate to 32767.
   always_comb begin
      mag_c = bus.sample_i;
      if (bus.sample_i == 16'h8000)
         mag_c = 16'h7fff;
      else if (bus.sample_i[15])
         mag_c = ~bus.sample_i + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peak_trk   <= '0;
         bus.peak_o <= '0;
      end else begin
         if (clear_c)
            peak_trk <= '0;
         else if (take_c && (mag_c > peak_trk))
            peak_trk <= mag_c;
         if (state == CALC)
            bus.peak_o <= peak_trk;
      end
   end
`else
   assign bus.peak_o = '0;
`endif

endmodule

// File: tb/tb_noise_stat_estimator.sv
// Bench for noise_stat_estimator: directed and random
// windows checked against an arithmetic reference model.
module tb_noise_stat_estimator;
   typedef logic signed [15:0] sq_t[$];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   noise_stat_estimator_if a ();
   noise_stat_estimator_if b ();

   noise_stat_estimator #(
      .LOG2_N(4),
      .CONTINUOUS(1'b0)
   ) dut_a (
      .clk(clk),
      .rst(rst),
      .bus(a.slave)
   );

   noise_stat_estimator #(
      .LOG2_N(2),
      .CONTINUOUS(1'b1)
   ) dut_b (
      .clk(clk),
      .rst(rst),
      .bus(b.slave)
   );

   int npass = 0;
   int ntot  = 0;
   int na    = 0;

   always @(posedge clk)
      if (a.stat_valid_o) na <= na + 1;

   task automatic chk(input string tag,
                      input longint obs,
                      input longint exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0d expected %0d",
                  tag, obs, exp);
   endtask

   function automatic void model(input sq_t q,
                                 input int l2,
                                 output longint m,
                                 output longint v,
                                 output longint pk);
      longint s, ss, n, x, ax;
      s  = 0;
      ss = 0;
      pk = 0;
      n  = longint'(1) << l2;
      foreach (q[i]) begin
         x  = q[i];
         s  += x;
         ss += x * x;
         ax = (x < 0) ? -x : x;
         if (ax > 32767) ax = 32767;
         if (ax > pk) pk = ax;
      end
      m = s / n;
      if ((s % n != 0) && (s < 0)) m--;
      v = ss / n - m * m;
      if (v < 0) v = 0;
      if (v > 64'hffff_ffff) v = 64'hffff_ffff;
`ifndef NOISE_STAT_PEAK_EN
      pk = 0;
`endif
   endfunction

   task automatic run_a(input string tag, input sq_t q,
                        input int gmin, input int gmax);
      longint m, v, pk;
      int n0;
      model(q, 4, m, v, pk);
      n0 = na;
      chk({tag, "_idle_busy"}, a.busy_o, 0);
      a.start_i        = 1'b1;
      a.sample_valid_i = 1'b1;
      a.sample_i       = 16'($urandom);
      @(negedge clk);
      a.start_i = 1'b0;
      chk({tag, "_busy"}, a.busy_o, 1);
      foreach (q[i]) begin
         repeat ($urandom_range(gmax, gmin)) begin
            a.sample_valid_i = 1'b0;
            a.sample_i       = 16'($urandom);
            @(negedge clk);
         end
         a.sample_valid_i = 1'b1;
         a.sample_i       = q[i];
         a.start_i        = 1'($urandom);
         @(negedge clk);
      end
      a.sample_valid_i = 1'b0;
      a.start_i        = 1'b0;
      chk({tag, "_early"}, a.stat_valid_o, 0);
      @(negedge clk);
      chk({tag, "_strobe"}, a.stat_valid_o, 1);
      chk({tag, "_mean"}, longint'(a.mean_o), m);
      chk({tag, "_var"}, longint'(a.var_o), v);
      chk({tag, "_peak"}, longint'(a.peak_o), pk);
      @(negedge clk);
      chk({tag, "_strobe_off"}, a.stat_valid_o, 0);
      chk({tag, "_busy_off"}, a.busy_o, 0);
      chk({tag, "_hold"}, longint'(a.mean_o), m);
      chk({tag, "_npulse"}, na - n0, 1);
   endtask

   initial begin
      sq_t q;
      sq_t w;
      logic signed [15:0] drv[0:99];
      longint m, v, pk;
      int n0;

      rst              = 1'b1;
      a.start_i        = 1'b0;
      a.sample_i       = '0;
      a.sample_valid_i = 1'b0;
      b.start_i        = 1'b0;
      b.sample_i       = '0;
      b.sample_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", a.busy_o, 0);
      chk("rst_sv", a.stat_valid_o, 0);
      chk("rst_mean", longint'(a.mean_o), 0);
      chk("rst_var", longint'(a.var_o), 0);
      chk("rst_peak", longint'(a.peak_o), 0);
      chk("rst_b_busy", b.busy_o, 0);
      rst = 1'b0;
      @(negedge clk);

      // Samples while idle are ignored.
      a.sample_valid_i = 1'b1;
      a.sample_i       = 16'sd1000;
      repeat (3) @(negedge clk);
      chk("idle_ignore", a.busy_o, 0);

      q = {};
      repeat (16) q.push_back(16'sd128);
      run_a("const128", q, 0, 0);

      q = {};
      for (int i = 0; i < 16; i++)
         q.push_back((i % 2 == 0) ? 16'sd128 : -16'sd128);
      run_a("alt128", q, 1, 1);

      q = {};
      for (int i = 0; i < 16; i++)
         q.push_back(16'(i));
      run_a("ramp", q, 0, 0);

      q = {};
      repeat (16) q.push_back(-16'sd32768);
      run_a("minval", q, 0, 0);

      for (int r = 0; r < 6; r++) begin
         q = {};
         for (int i = 0; i < 16; i++)
            if (r < 3)
               q.push_back(16'($urandom));
            else
               q.push_back(16'($urandom_range(600, 0)) -
                           16'sd300);
         run_a($sformatf("rand%0d", r), q, 0, 3);
      end

      // Abort a window halfway with reset.
      n0 = na;
      a.start_i = 1'b1;
      @(negedge clk);
      a.start_i = 1'b0;
      repeat (8) begin
         a.sample_valid_i = 1'b1;
         a.sample_i       = 16'sd999;
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      chk("abort_busy", a.busy_o, 0);
      chk("abort_mean", longint'(a.mean_o), 0);
      chk("abort_var", longint'(a.var_o), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_nostrobe", na - n0, 0);

      // Start coincident with reset is lost.
      rst       = 1'b1;
      a.start_i = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      a.start_i = 1'b0;
      @(negedge clk);
      chk("rst_wins", a.busy_o, 0);

      q = {};
      repeat (16) q.push_back(16'sd64);
      run_a("after_abort", q, 0, 0);

      // Continuous mode: window drv[k-5..k-2] reports at k.
      b.start_i        = 1'b1;
      b.sample_valid_i = 1'b1;
      b.sample_i       = 16'sd256;
      drv[0]           = 16'sd256;
      for (int k = 1; k < 60; k++) begin
         @(negedge clk);
         chk($sformatf("b_busy%0d", k), b.busy_o, 1);
         chk($sformatf("b_sv%0d", k), b.stat_valid_o,
             (k % 6 == 0) ? 1 : 0);
         if (k % 6 == 0) begin
            w = {};
            for (int j = k - 5; j <= k - 2; j++)
               w.push_back(drv[j]);
            model(w, 2, m, v, pk);
            chk($sformatf("b_mean%0d", k),
                longint'(b.mean_o), m);
            chk($sformatf("b_var%0d", k),
                longint'(b.var_o), v);
         end
         b.start_i = ((k % 6) >= 1 && (k % 6) <= 4) ?
                     1'($urandom) : 1'b0;
         drv[k] = (k < 14) ? 16'sd256 : 16'($urandom);
         b.sample_i = drv[k];
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
